// File: rtl/reg_dump_if.sv
// Command, register-file read port and byte-stream signals of the register dump sequencer.
// master = the sequencer, slave = its environment (command source, register file, consumer).
interface reg_dump_if #(parameter int pw = 4);
   logic          start;
   logic [pw-1:0] base_addr;
   logic [pw:0]   count;
   logic [pw-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [7:0]    out_data;
   logic [pw-1:0] out_addr;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic [7:0]    checksum;

   modport master (
      input  start, base_addr, count, rd_data, out_ready,
      output rd_addr, out_data, out_addr, out_valid, busy, done, checksum
   );
   modport slave (
      output start, base_addr, count, rd_data, out_ready,
      input  rd_addr, out_data, out_addr, out_valid, busy, done, checksum
   );
endinterface

// File: rtl/reg_dump.sv
// Sweeps a contiguous (wrapping) register range through one read port and streams the
// bytes over valid/ready, keeping a running XOR checksum and pulsing done at the end.
module reg_dump #(
   parameter int pw = 4
) (
   input  logic         clk,
   input  logic         reset,
   reg_dump_if.master   bus
);
   typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

   localparam logic [pw:0]   REM_ONE  = (pw+1)'(1);
   localparam logic [pw-1:0] ADDR_ONE = pw'(1);

   state_t        state_q;
   logic [pw-1:0] cur_addr_q;
   logic [pw:0]   remaining_q;
   logic [7:0]    out_data_q;
   logic [pw-1:0] out_addr_q;
   logic          out_valid_q;
   logic          busy_q;
   logic          done_q;
   logic [7:0]    checksum_q;

   // Every output is a flop, so out_ready never reaches out_valid combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         checksum_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  cur_addr_q  <= bus.base_addr;
                  remaining_q <= bus.count;
                  checksum_q  <= '0;
                  busy_q      <= 1'b1;
                  if (bus.count != '0) begin
                     state_q <= FETCH;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               // rd_data is sampled before this edge, so a same-cycle write is not seen.
               out_data_q  <= bus.rd_data;
               out_addr_q  <= cur_addr_q;
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  checksum_q  <= checksum_q ^ out_data_q;
                  remaining_q <= remaining_q - REM_ONE;
                  out_valid_q <= 1'b0;
                  if (remaining_q == REM_ONE) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end else begin
                     cur_addr_q <= cur_addr_q + ADDR_ONE;
                     state_q    <= FETCH;
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rd_addr   = cur_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.checksum  = checksum_q;
endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: directed scenarios plus random commands with random backpressure,
// checked against a model that derives each beat from base+k mod 16 and a register snapshot.
module tb_reg_dump;
   logic clk = 1'b0;
   logic reset;
   logic [7:0] regs [16];
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   int checks = 0;
   int errors = 0;

   reg_dump_if #(.pw(4)) bus ();

   reg_dump #(.pw(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Register file: preloaded to 8'h10+i during reset, one write port, combinational read.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h10 + 8'(i);
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end
   assign bus.rd_data = regs[bus.rd_addr];

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_addr"},   32'(bus.rd_addr),   0);
      chk({tag, "_out_data"},  32'(bus.out_data),  0);
      chk({tag, "_out_addr"},  32'(bus.out_addr),  0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_busy"},      32'(bus.busy),      0);
      chk({tag, "_done"},      32'(bus.done),      0);
      chk({tag, "_checksum"},  32'(bus.checksum),  0);
   endtask

   // mode 0: ready always high (cycle-exact timing checked), 1: random ready,
   // 2: ready low for the first 5 cycles of beat 0. coll_c/start_c/abort_c select the cycle
   // (relative to the start edge T) for a same-address write, a stray start, or a reset.
   task automatic run_cmd(input int base, input int cnt, input int mode,
                          input int coll_c, input int start_c, input int abort_c);
      logic [7:0] snap [16];
      logic [7:0] exp_cs;
      logic [7:0] pd;
      logic [3:0] pa;
      int  k, c, stall, ea;
      bit  fin, ready, hold;
      for (int i = 0; i < 16; i++) snap[i] = regs[i];
      bus.start     = 1'b1;
      bus.base_addr = base[3:0];
      bus.count     = cnt[4:0];
      tick;
      bus.start = 1'b0;
      c = 1; k = 0; stall = 0; exp_cs = 8'h00; fin = 1'b0; hold = 1'b0; pd = 8'h00; pa = 4'h0;
      while (!fin && c < 400) begin
         if (c == abort_c) begin
            reset = 1'b1;
            tick;
            reset = 1'b0;
            chk_reset_outputs("abort");
            for (int j = 0; j < 4; j++) begin
               tick;
               chk("abort_no_done", 32'(bus.done), 0);
               chk("abort_no_beat", 32'(bus.out_valid), 0);
            end
            return;
         end
         chk("busy_during_cmd", 32'(bus.busy), 1);
         if (bus.done) begin
            chk("beats_at_done", k, cnt);
            chk("checksum_at_done", 32'(bus.checksum), 32'(exp_cs));
            if (mode == 0) chk("done_cycle", c, 2 * cnt + 1);
            fin = 1'b1;
         end
         if (hold) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data",  32'(bus.out_data), 32'(pd));
            chk("stall_addr",  32'(bus.out_addr), 32'(pa));
         end
         case (mode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(0, 3) != 0);
            default: ready = !(k == 0 && stall < 5);
         endcase
         if (bus.out_valid) begin
            chk("extra_beat", 32'(k < cnt), 1);
            ea = (base + k) % 16;
            chk("beat_addr", 32'(bus.out_addr), ea);
            chk("beat_data", 32'(bus.out_data), 32'(snap[ea]));
            if (ready) begin
               if (mode == 0) chk("beat_cycle", c, 2 + 2 * k);
               exp_cs = exp_cs ^ snap[ea];
               k++;
               hold = 1'b0;
            end else begin
               stall++;
               hold = 1'b1;
               pd = snap[ea];
               pa = ea[3:0];
            end
         end
         wr_en = (c == coll_c);
         if (c == start_c) begin
            bus.start     = 1'b1;
            bus.base_addr = 4'd0;
            bus.count     = 5'd1;
         end else begin
            bus.start = 1'b0;
         end
         bus.out_ready = ready;
         tick;
         c++;
      end
      wr_en = 1'b0;
      bus.start = 1'b0;
      chk("cmd_timeout", 32'(fin), 1);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_done", 32'(bus.done), 0);
      chk("idle_valid", 32'(bus.out_valid), 0);
      chk("idle_checksum", 32'(bus.checksum), 32'(exp_cs));
      if (mode == 2) chk("stall_cycles", stall, 5);
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      wr_addr = 4'd5;
      wr_data = 8'hAA;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.count = '0;
      bus.out_ready = 1'b0;
      tick;
      tick;
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick;
      chk_reset_outputs("idle_after_reset");

      run_cmd(4, 3, 0, -1, -1, -1);
      chk("basic_checksum", 32'(bus.checksum), 32'h17);

      run_cmd(14, 4, 0, -1, -1, -1);
      chk("wrap_checksum", 32'(bus.checksum), 32'h00);

      run_cmd(0, 2, 2, -1, -1, -1);

      run_cmd(7, 0, 0, -1, -1, -1);
      chk("zero_checksum", 32'(bus.checksum), 32'h00);

      // Write r5 during its FETCH (T+3) and pulse start during SEND (T+2).
      run_cmd(4, 3, 0, 3, 2, -1);
      chk("collision_write_landed", 32'(regs[5]), 32'hAA);

      // Reset during SEND of beat 1, then an ordinary command.
      run_cmd(4, 5, 0, -1, -1, 4);
      run_cmd(2, 3, 0, -1, -1, -1);

      for (int r = 0; r < 6; r++) begin
         run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 1, -1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
